// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle for mux2_rr_arbiter: two producer streams, one consumer stream, status.
// MUX2_ARB_BURST_EN adds the per-beat last flags and the lock-state debug view.
interface mux2_rr_arbiter_if #(
    parameter int W     = 8,
    parameter int CNT_W = 8
);
    logic             io_in0_valid;
    logic             io_in0_ready;
    logic [W-1:0]     io_in0_bits;
    logic             io_in1_valid;
    logic             io_in1_ready;
    logic [W-1:0]     io_in1_bits;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [W-1:0]     io_out_bits;
    logic             io_sel;
    logic [CNT_W-1:0] io_cnt0;
    logic [CNT_W-1:0] io_cnt1;
`ifdef MUX2_ARB_BURST_EN
    logic             io_in0_last;
    logic             io_in1_last;
    logic             io_out_last;
    logic [1:0]       dbg_lock_state;

    modport slave (
        input  io_in0_valid, io_in0_bits, io_in0_last,
        input  io_in1_valid, io_in1_bits, io_in1_last,
        input  io_out_ready,
        output io_in0_ready, io_in1_ready,
        output io_out_valid, io_out_bits, io_out_last,
        output io_sel, io_cnt0, io_cnt1, dbg_lock_state
    );

    modport master (
        output io_in0_valid, io_in0_bits, io_in0_last,
        output io_in1_valid, io_in1_bits, io_in1_last,
        output io_out_ready,
        input  io_in0_ready, io_in1_ready,
        input  io_out_valid, io_out_bits, io_out_last,
        input  io_sel, io_cnt0, io_cnt1, dbg_lock_state
    );
`else
    modport slave (
        input  io_in0_valid, io_in0_bits,
        input  io_in1_valid, io_in1_bits,
        input  io_out_ready,
        output io_in0_ready, io_in1_ready,
        output io_out_valid, io_out_bits,
        output io_sel, io_cnt0, io_cnt1
    );

    modport master (
        output io_in0_valid, io_in0_bits,
        output io_in1_valid, io_in1_bits,
        output io_out_ready,
        input  io_in0_ready, io_in1_ready,
        input  io_out_valid, io_out_bits,
        input  io_sel, io_cnt0, io_cnt1
    );
`endif
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 mux between two valid/ready producers, one-entry output stage.
// Optional MUX2_ARB_BURST_EN: a grant with last=0 locks the arbiter to that requester until last=1.
module mux2_rr_arbiter #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    mux2_rr_arbiter_if.slave io
);
    // Valid/ready: a beat moves when valid && ready at posedge. Ready is the arbitration
    // result (slot free and this requester wins) and never waits on its own valid otherwise.
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             free;
    logic             rr0, rr1;
    logic             gnt0, gnt1;
    logic             ready0, ready1;
    logic             xfer0, xfer1;
    logic             out_valid_q;
    logic [W-1:0]     out_bits_q;
    logic             sel_q;
    logic             last_grant_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

`ifdef MUX2_ARB_BURST_EN
    typedef enum logic [1:0] {
        ST_OPEN  = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } lock_state_t;

    lock_state_t state_q, state_d;
    logic        out_last_q;
`endif

    always_comb begin
        free = !out_valid_q || io.io_out_ready;
        rr0  = 1'b0;
        rr1  = 1'b0;
        if (io.io_in0_valid && io.io_in1_valid) begin
            rr0 = last_grant_q;
            rr1 = !last_grant_q;
        end else begin
            rr0 = io.io_in0_valid;
            rr1 = io.io_in1_valid;
        end
`ifdef MUX2_ARB_BURST_EN
        gnt0 = (state_q == ST_LOCK0) || ((state_q == ST_OPEN) && rr0);
        gnt1 = (state_q == ST_LOCK1) || ((state_q == ST_OPEN) && rr1);
`else
        gnt0 = rr0;
        gnt1 = rr1;
`endif
        ready0 = !reset && free && gnt0;
        ready1 = !reset && free && gnt1;
        xfer0  = io.io_in0_valid && ready0;
        xfer1  = io.io_in1_valid && ready1;
    end

`ifdef MUX2_ARB_BURST_EN
    always_comb begin
        state_d = state_q;
        if (xfer0) begin
            state_d = io.io_in0_last ? ST_OPEN : ST_LOCK0;
        end else if (xfer1) begin
            state_d = io.io_in1_last ? ST_OPEN : ST_LOCK1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_OPEN;
        else       state_q <= state_d;
    end
`endif

    // last_grant resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
`ifdef MUX2_ARB_BURST_EN
            out_last_q   <= 1'b0;
`endif
        end else if (xfer0 || xfer1) begin
            out_valid_q  <= 1'b1;
            out_bits_q   <= xfer1 ? io.io_in1_bits : io.io_in0_bits;
            sel_q        <= xfer1;
            last_grant_q <= xfer1;
            if (xfer0) cnt0_q <= cnt0_q + CNT_ONE;
            if (xfer1) cnt1_q <= cnt1_q + CNT_ONE;
`ifdef MUX2_ARB_BURST_EN
            out_last_q   <= xfer1 ? io.io_in1_last : io.io_in0_last;
`endif
        end else if (out_valid_q && io.io_out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign io.io_in0_ready = ready0;
    assign io.io_in1_ready = ready1;
    assign io.io_out_valid = out_valid_q;
    assign io.io_out_bits  = out_bits_q;
    assign io.io_sel       = sel_q;
    assign io.io_cnt0      = cnt0_q;
    assign io.io_cnt1      = cnt1_q;
`ifdef MUX2_ARB_BURST_EN
    assign io.io_out_last    = out_last_q;
    assign io.dbg_lock_state = state_q;
`endif
endmodule
